// File: rtl/hex_scan.sv
// Purpose: 4-digit common-anode 7-segment scanner with frame-synchronous commit of loaded digits.
// Latency: outputs registered one cycle behind (cnt, slot); a load reaches the pins within 4*DIV+DEAD+1 cycles.
// Backpressure: none; load_i is always accepted, and a newer load overwrites an uncommitted one.
module hex_scan #(
    parameter int DIV  = 100000,
    parameter int DEAD = 16
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [15:0] data_i,
    input  logic [3:0]  en_i,
    input  logic [3:0]  dp_i,
    input  logic        load_i,
    output logic [6:0]  hex_o,
    output logic        dp_o,
    output logic [3:0]  an_o,
    output logic        frame_o,
    output logic        pending_o
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] DEAD_C  = CW'(DEAD);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    slot_q, slot_d;
    logic          wrap, boundary;

    logic [15:0] pend_data_q, pend_data_d;
    logic [3:0]  pend_en_q, pend_en_d;
    logic [3:0]  pend_dp_q, pend_dp_d;
    logic        pend_vld_q, pend_vld_d;
    logic [15:0] disp_data_q, disp_data_d;
    logic [3:0]  disp_en_q, disp_en_d;
    logic [3:0]  disp_dp_q, disp_dp_d;

    logic [6:0] hex_q, hex_d;
    logic       dp_q, dp_d;
    logic [3:0] an_q, an_d;
    logic       frame_q;

    logic [3:0] nib;
    logic [3:0] an_sel;
    logic [6:0] seg_pat;
    logic       lit;

    assign wrap     = (cnt_q == CNT_MAX);
    assign boundary = wrap && (slot_q == 2'd3);

    // Prescaler and slot index: slot advances on every prescaler wrap.
    always_comb begin
        cnt_d  = wrap ? '0 : cnt_q + CNT_ONE;
        slot_d = wrap ? slot_q + 2'd1 : slot_q;
    end

    // Pending capture and frame-boundary commit; a load on the boundary goes straight to display.
    always_comb begin
        pend_data_d = pend_data_q;
        pend_en_d   = pend_en_q;
        pend_dp_d   = pend_dp_q;
        pend_vld_d  = pend_vld_q;
        disp_data_d = disp_data_q;
        disp_en_d   = disp_en_q;
        disp_dp_d   = disp_dp_q;
        if (load_i && boundary) begin
            disp_data_d = data_i;
            disp_en_d   = en_i;
            disp_dp_d   = dp_i;
            pend_vld_d  = 1'b0;
        end else if (load_i) begin
            pend_data_d = data_i;
            pend_en_d   = en_i;
            pend_dp_d   = dp_i;
            pend_vld_d  = 1'b1;
        end else if (boundary && pend_vld_q) begin
            disp_data_d = pend_data_q;
            disp_en_d   = pend_en_q;
            disp_dp_d   = pend_dp_q;
            pend_vld_d  = 1'b0;
        end
    end

    // Select the digit for the current slot and build the next pin pattern.
    always_comb begin
        nib    = 4'h0;
        an_sel = 4'b1111;
        case (slot_q)
            2'd0: begin nib = disp_data_q[3:0];   an_sel = 4'b1110; end
            2'd1: begin nib = disp_data_q[7:4];   an_sel = 4'b1101; end
            2'd2: begin nib = disp_data_q[11:8];  an_sel = 4'b1011; end
            default: begin nib = disp_data_q[15:12]; an_sel = 4'b0111; end
        endcase

        case (nib)
            4'h0: seg_pat = 7'h40;
            4'h1: seg_pat = 7'h79;
            4'h2: seg_pat = 7'h24;
            4'h3: seg_pat = 7'h30;
            4'h4: seg_pat = 7'h19;
            4'h5: seg_pat = 7'h12;
            4'h6: seg_pat = 7'h02;
            4'h7: seg_pat = 7'h78;
            4'h8: seg_pat = 7'h00;
            4'h9: seg_pat = 7'h10;
            4'hA: seg_pat = 7'h08;
            4'hB: seg_pat = 7'h03;
            4'hC: seg_pat = 7'h46;
            4'hD: seg_pat = 7'h21;
            4'hE: seg_pat = 7'h06;
            default: seg_pat = 7'h0E;
        endcase

        // Blank during the dead window and for disabled digits.
        lit  = (cnt_q >= DEAD_C) && disp_en_q[slot_q];
        an_d  = lit ? an_sel : 4'b1111;
        hex_d = lit ? seg_pat : 7'h7F;
        dp_d  = lit ? ~disp_dp_q[slot_q] : 1'b1;
    end

    // All state and pin registers; reset discards everything and leaves the display dark.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q       <= '0;
            slot_q      <= 2'd0;
            pend_data_q <= 16'h0;
            pend_en_q   <= 4'h0;
            pend_dp_q   <= 4'h0;
            pend_vld_q  <= 1'b0;
            disp_data_q <= 16'h0;
            disp_en_q   <= 4'h0;
            disp_dp_q   <= 4'h0;
            hex_q       <= 7'h7F;
            dp_q        <= 1'b1;
            an_q        <= 4'hF;
            frame_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            pend_data_q <= pend_data_d;
            pend_en_q   <= pend_en_d;
            pend_dp_q   <= pend_dp_d;
            pend_vld_q  <= pend_vld_d;
            disp_data_q <= disp_data_d;
            disp_en_q   <= disp_en_d;
            disp_dp_q   <= disp_dp_d;
            hex_q       <= hex_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            frame_q     <= boundary;
        end
    end

    assign hex_o     = hex_q;
    assign dp_o      = dp_q;
    assign an_o      = an_q;
    assign frame_o   = frame_q;
    assign pending_o = pend_vld_q;

endmodule

// File: tb/tb_hex_scan.sv
// Purpose: scoreboard bench for hex_scan with DIV=8, DEAD=2; expected lit windows queued per frame.
// Latency: a monitor pops one expectation at the start of every lit window and checks its shape.
// Backpressure: not applicable; stimulus is directed loads at chosen frame phases.
module tb_hex_scan;

    localparam int DIV   = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk_i  = 1'b0;
    logic        rstn_i = 1'b0;
    logic [15:0] data_i = 16'h0;
    logic [3:0]  en_i   = 4'h0;
    logic [3:0]  dp_i   = 4'h0;
    logic        load_i = 1'b0;
    logic [6:0]  hex_o;
    logic        dp_o;
    logic [3:0]  an_o;
    logic        frame_o;
    logic        pending_o;

    hex_scan #(.DIV(DIV), .DEAD(DEAD)) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .data_i    (data_i),
        .en_i      (en_i),
        .dp_i      (dp_i),
        .load_i    (load_i),
        .hex_o     (hex_o),
        .dp_o      (dp_o),
        .an_o      (an_o),
        .frame_o   (frame_o),
        .pending_o (pending_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] hex;
        logic       dp;
        logic       chk_gap;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Bench-side frame phase: cycles since reset release, modulo one frame.
    int tb_ph  = 0;
    bit fr_exp = 1'b0;

    // Bench model of pending and committed display contents.
    logic [15:0] m_pd = 16'h0, m_dd = 16'h0;
    logic [3:0]  m_pe = 4'h0, m_de = 4'h0, m_pp = 4'h0, m_dp = 4'h0;
    bit          m_pv = 1'b0;
    bit          last_en3 = 1'b0;
    exp_t        ne;

    // Monitor state.
    bit          in_win = 1'b0;
    int          win_len = 0;
    int          gap = 0;
    logic [11:0] cur = 12'h0;
    exp_t        pe;

    function automatic logic [6:0] seg_ref(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tb_ph  = 0;
            fr_exp = 1'b0;
        end else begin
            fr_exp = (tb_ph == FRAME - 1);
            tb_ph  = (tb_ph + 1) % FRAME;
        end
    end

    // Model: commit at each frame start, queue that frame's lit windows, track pending_o.
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            m_pv = 1'b0; m_dd = 16'h0; m_de = 4'h0; m_dp = 4'h0; last_en3 = 1'b0;
            q.delete();
        end else begin
            if (fr_exp) begin
                chk("drain", q.size(), 0);
                if (m_pv) begin
                    m_dd = m_pd; m_de = m_pe; m_dp = m_pp; m_pv = 1'b0;
                end
                for (int s = 0; s < 4; s++) begin
                    if (m_de[s]) begin
                        ne.an      = ~(4'b0001 << s);
                        ne.hex     = seg_ref(m_dd[4*s +: 4]);
                        ne.dp      = ~m_dp[s];
                        ne.chk_gap = (s == 0) ? last_en3 : m_de[(s + 3) % 4];
                        q.push_back(ne);
                    end
                end
                last_en3 = m_de[3];
            end
            chk("pending", pending_o, m_pv);
        end
    end

    // Monitor: frame pulse, blank pattern, and each lit window's content, length and lead-in gap.
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            in_win = 1'b0; win_len = 0; gap = 0;
        end else begin
            chk("frame", frame_o, fr_exp);
            if (an_o == 4'hF) begin
                chk("blank", {hex_o, dp_o}, {7'h7F, 1'b1});
                if (in_win) begin
                    chk("win_len", win_len, DIV - DEAD);
                    in_win = 1'b0;
                    gap = 0;
                end
                gap++;
            end else if (!in_win) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_window: got an=%b hex=%h dp=%b want dark at %0t",
                             an_o, hex_o, dp_o, $time);
                end else begin
                    pe = q.pop_front();
                    chk("digit", {an_o, hex_o, dp_o}, {pe.an, pe.hex, pe.dp});
                    if (pe.chk_gap) chk("gap", gap, DEAD);
                    else            chk("gap_min", 32'(gap >= DEAD), 1);
                end
                in_win = 1'b1; win_len = 1; cur = {an_o, hex_o, dp_o};
            end else begin
                chk("steady", {an_o, hex_o, dp_o}, cur);
                win_len++;
            end
        end
    end

    task automatic wait_frames(input int n);
        int seen = 0;
        int guard = 0;
        while (seen < n && guard < (n + 1) * FRAME) begin
            @(negedge clk_i);
            guard++;
            if (fr_exp) seen++;
        end
        if (seen < n) begin
            total++; bad++;
            $display("FAIL wait_frames: got %0d frames want %0d", seen, n);
        end
    endtask

    // Drive a one-cycle load; at_ph >= 0 aligns the capturing edge so the prior phase equals at_ph.
    task automatic do_load(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p, input int at_ph);
        int guard = 0;
        bit bnd;
        @(posedge clk_i); #1;
        if (at_ph >= 0) begin
            while (tb_ph != at_ph && guard < 2 * FRAME) begin
                @(posedge clk_i); #1;
                guard++;
            end
        end
        bnd = (tb_ph == FRAME - 1);
        data_i = d; en_i = e; dp_i = p; load_i = 1'b1;
        @(posedge clk_i);
        if (bnd) begin
            m_dd = d; m_de = e; m_dp = p; m_pv = 1'b0;
        end else begin
            m_pd = d; m_pe = e; m_pp = p; m_pv = 1'b1;
        end
        #1 load_i = 1'b0;
    endtask

    initial begin
        int guard;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_an", an_o, 4'hF);
        chk("rst_hex", hex_o, 7'h7F);
        chk("rst_dp", dp_o, 1'b1);
        chk("rst_frame", frame_o, 1'b0);
        chk("rst_pending", pending_o, 1'b0);
        rstn_i = 1'b1;

        // Dark after release with no load.
        wait_frames(3);

        do_load(16'h1234, 4'hF, 4'b0100, -1);
        wait_frames(2);

        do_load(16'h3210, 4'hF, 4'h0, -1); wait_frames(2);
        do_load(16'h7654, 4'hF, 4'h0, -1); wait_frames(2);
        do_load(16'hBA98, 4'hF, 4'h0, -1); wait_frames(2);
        do_load(16'hFEDC, 4'hF, 4'h0, -1); wait_frames(2);

        do_load(16'h8888, 4'b0101, 4'h0, -1);
        wait_frames(2);

        // Mid-frame load: old digits must finish the current frame.
        repeat (10) @(posedge clk_i);
        do_load(16'hAAAA, 4'hF, 4'h0, -1);
        wait_frames(2);

        // Load on the boundary cycle itself.
        do_load(16'h0F5C, 4'hF, 4'b1001, FRAME - 1);
        wait_frames(2);

        // Reset while lit with a load still pending.
        do_load(16'h4321, 4'hF, 4'hF, -1);
        guard = 0;
        do begin
            @(negedge clk_i);
            guard++;
        end while (an_o == 4'hF && guard < 2 * FRAME);
        if (an_o == 4'hF) begin
            total++; bad++;
            $display("FAIL lit_before_reset: got an=%b want lit", an_o);
        end
        #2 rstn_i = 1'b0;
        #1;
        chk("arst_an", an_o, 4'hF);
        chk("arst_hex", hex_o, 7'h7F);
        chk("arst_dp", dp_o, 1'b1);
        chk("arst_pending", pending_o, 1'b0);
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        wait_frames(3);
        chk("post_rst_an", an_o, 4'hF);

        repeat (2) @(negedge clk_i);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_scan.md
# hex_scan

Time-multiplexed 4-digit 7-segment display driver sitting directly downstream of the switch decoder. It captures four 4-bit digit codes plus per-digit enable and decimal-point bits on a load strobe, and commits them at the next frame boundary to avoid tearing. It then scans the common-anode display one digit per slot, converting each nibble to an active-low segment pattern. A blanking interval at the start of every slot suppresses ghosting.

## Interface
- DIV, 100000: clock cycles per digit slot (1 ms at 100 MHz); legal range DIV >= 4.
- DEAD, 16: blanked cycles at the start of each slot; legal range 1 <= DEAD < DIV.
- clk_i  input  1  system clock; all state on rising edge.
- rstn_i  input  1  reset, asynchronous, active-low.
- data_i  input  16  digit codes; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
- en_i  input  4  per-digit enable; 0 keeps that digit dark.
- dp_i  input  4  per-digit decimal point request, 1 = lit.
- load_i  input  1  one-cycle strobe; captures data_i/en_i/dp_i into the pending register.
- hex_o  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_o  output  1  decimal point, active-low.
- an_o  output  4  digit anodes, active-low one-hot (or all 1 when blank).
- frame_o  output  1  one-cycle pulse at the start of each frame.
- pending_o  output  1  high while captured data awaits commit.

## Operation
- Registers: prescaler cnt (0..DIV-1), slot (0..3), pending {data,en,dp} plus valid flag, display {data,en,dp}.
- cnt increments every cycle and wraps DIV-1 -> 0. slot increments on each cnt wrap and wraps 3 -> 0.
- Frame boundary: the cycle where cnt == DIV-1 and slot == 3.
- load_i = 1: pending <= inputs, pending_o <= 1. Back-to-back loads: the last one wins.
- At a frame boundary with pending valid: display <= pending, pending_o <= 0.
- load_i on a frame-boundary cycle: the inputs bypass straight into display, and pending_o is 0 afterwards.
- Slot s, cnt < DEAD: an_o = 4'b1111, hex_o = 7'h7F, dp_o = 1.
- Slot s, cnt >= DEAD, en[s] = 1: an_o = ~(1 << s), hex_o = seg(data[4s+3:4s]), dp_o = ~dp[s].
- Slot s, cnt >= DEAD, en[s] = 0: same as blank.
- seg() in hex, active-low gfedcba:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- No arithmetic beyond the counters. cnt width = clog2(DIV). slot is 2 bits with natural wrap.

## Timing
- Reset (async assert):
  - Immediately: cnt = 0, slot = 0, pending = 0, display = 0.
  - Outputs: an_o = 4'hF, hex_o = 7'h7F, dp_o = 1, frame_o = 0, pending_o = 0.
  - Reset mid-scan or mid-pending discards all data. After release, the display stays dark until a load commits.
- All outputs are registered and lag the (cnt, slot) state by one cycle. an_o, hex_o and dp_o change together in the same cycle, never skewed.
- The first lit cycle of slot s is DEAD+1 cycles after cnt wraps to 0, because of the one-cycle output register.
- frame_o: high for exactly one cycle, the cycle after each frame boundary, every 4*DIV cycles.
- Commit latency: from load_i to the new pattern on the pins is at most 4*DIV + DEAD + 1 cycles.
- pending_o rises the cycle after load_i and falls the cycle after the commit boundary.
- Committed data changes only at frame boundaries, so a frame never mixes old and new digits.

## Test plan
All scenarios use DIV = 8, DEAD = 2.
- Reset, then release with no load:
  - an_o stays 4'hF and hex_o stays 7'h7F for 3 frames.
  - frame_o pulses every 32 cycles.
- load_i with data_i = 16'h1234, en_i = 4'hF, dp_i = 4'b0100:
  - After the next frame boundary: slot 0 gives an_o = 4'b1110, hex_o = 7'h19.
  - Slot 1: an_o = 4'b1101, hex_o = 7'h30.
  - Slot 2: an_o = 4'b1011, hex_o = 7'h24, dp_o = 0.
  - Slot 3: an_o = 4'b0111, hex_o = 7'h79.
  - Each lit window is 6 cycles preceded by 2 blank cycles.
- All 16 codes over four loads (16'h3210, 16'h7654, 16'hBA98, 16'hFEDC): hex_o matches the seg() list for every slot.
- en_i = 4'b0101 with data_i = 16'h8888: slots 1 and 3 stay fully blank; slots 0 and 2 show hex_o = 7'h00.
- Tearing and boundary cases:
  - Load 16'hAAAA mid-frame: pending_o = 1 until the boundary, and the current frame still shows the old data.
  - load_i exactly on the boundary cycle: the next frame shows the new data, and pending_o stays 0.
- Assert rstn_i low mid-slot while lit: outputs go dark in the same cycle, asynchronously, and stay dark after release until a new load commits.
